// File: rtl/ddr_mem_bridge_if.sv
// PicoRV32 native memory bus between the CPU (master) and the DDR bridge (slave).
interface ddr_mem_bridge_if;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_valid, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/ddr_mem_bridge.sv
// PicoRV32 bus to ddr_model bridge; partial writes done as read-modify-write.
// Optional read timeout: define DDR_MEM_BRIDGE_TIMEOUT_EN.
module ddr_mem_bridge #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_W         = 10,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  ddr_mem_bridge_if.slave       bus,
  output logic                  ddr_rd_req,
  output logic                  ddr_wr_req,
  output logic [ADDR_W-1:0]     ddr_addr,
  output logic [DATA_WIDTH-1:0] ddr_wr_data,
  input  logic [DATA_WIDTH-1:0] ddr_rd_data,
  input  logic                  ddr_rd_valid,
  output logic                  timeout_err
);

  localparam int NB = DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    IDLE, RD, RD_WAIT, WR, RMW_RD, RMW_WAIT, RMW_WR, RESP
  } state_t;

  state_t state, state_n;

  logic [ADDR_W-1:0]     addr_q, addr_n;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_n;
  logic [NB-1:0]         wstrb_q, wstrb_n;

  logic                  ready_q, ready_n;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_n;
  logic                  rd_req_n, wr_req_n;
  logic [ADDR_W-1:0]     daddr_n;
  logic [DATA_WIDTH-1:0] dwdata_n;

  // rd_valid is registered so a response in the rd_req cycle is not lost
  logic                  rv_q;
  logic [DATA_WIDTH-1:0] rd_q;
  logic [DATA_WIDTH-1:0] merged;

  logic unused_addr;
  assign unused_addr = ^{bus.mem_addr[31:ADDR_W+2], bus.mem_addr[1:0]};

`ifdef DDR_MEM_BRIDGE_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt, cnt_n;
  logic          expired;
  logic          terr_q, terr_n;
  assign expired     = (cnt == CW'(TIMEOUT_CYCLES - 1));
  assign timeout_err = terr_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES == 0);
  assign timeout_err    = 1'b0;
`endif

  assign bus.mem_ready = ready_q;
  assign bus.mem_rdata = rdata_q;

  always_comb begin
    merged = rd_q;
    for (int i = 0; i < NB; i++) begin
      if (wstrb_q[i]) merged[8*i +: 8] = wdata_q[8*i +: 8];
    end
  end

  always_comb begin
    state_n  = state;
    addr_n   = addr_q;
    wdata_n  = wdata_q;
    wstrb_n  = wstrb_q;
    ready_n  = 1'b0;
    rdata_n  = rdata_q;
    rd_req_n = 1'b0;
    wr_req_n = 1'b0;
    daddr_n  = ddr_addr;
    dwdata_n = ddr_wr_data;
`ifdef DDR_MEM_BRIDGE_TIMEOUT_EN
    cnt_n  = '0;
    terr_n = terr_q;
`endif
    unique case (state)
      IDLE: begin
        rdata_n = '0;
        if (bus.mem_valid) begin
          addr_n  = bus.mem_addr[ADDR_W+1:2];
          wdata_n = bus.mem_wdata;
          wstrb_n = bus.mem_wstrb;
          daddr_n = bus.mem_addr[ADDR_W+1:2];
          if (bus.mem_wstrb == '0) begin
            state_n  = RD;
            rd_req_n = 1'b1;
          end else if (bus.mem_wstrb == '1) begin
            state_n  = WR;
            wr_req_n = 1'b1;
            dwdata_n = bus.mem_wdata;
          end else begin
            state_n  = RMW_RD;
            rd_req_n = 1'b1;
          end
        end
      end
      RD: state_n = RD_WAIT;
      RD_WAIT: begin
`ifdef DDR_MEM_BRIDGE_TIMEOUT_EN
        cnt_n = cnt + CW'(1);
`endif
        if (rv_q) begin
          state_n = RESP;
          ready_n = 1'b1;
          rdata_n = rd_q;
        end
`ifdef DDR_MEM_BRIDGE_TIMEOUT_EN
        else if (expired) begin
          state_n = RESP;
          ready_n = 1'b1;
          rdata_n = 32'hDEAD_DEAD;
          terr_n  = 1'b1;
        end
`endif
      end
      WR: begin
        state_n = RESP;
        ready_n = 1'b1;
        rdata_n = '0;
      end
      RMW_RD: state_n = RMW_WAIT;
      RMW_WAIT: begin
`ifdef DDR_MEM_BRIDGE_TIMEOUT_EN
        cnt_n = cnt + CW'(1);
`endif
        if (rv_q) begin
          state_n  = RMW_WR;
          wr_req_n = 1'b1;
          dwdata_n = merged;
        end
`ifdef DDR_MEM_BRIDGE_TIMEOUT_EN
        else if (expired) begin
          state_n = RESP;
          ready_n = 1'b1;
          rdata_n = '0;
          terr_n  = 1'b1;
        end
`endif
      end
      RMW_WR: begin
        state_n = RESP;
        ready_n = 1'b1;
        rdata_n = '0;
      end
      RESP: begin
        state_n = IDLE;
        rdata_n = '0;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      ready_q     <= 1'b0;
      rdata_q     <= '0;
      ddr_rd_req  <= 1'b0;
      ddr_wr_req  <= 1'b0;
      ddr_addr    <= '0;
      ddr_wr_data <= '0;
      rv_q        <= 1'b0;
      rd_q        <= '0;
    end else begin
      state       <= state_n;
      addr_q      <= addr_n;
      wdata_q     <= wdata_n;
      wstrb_q     <= wstrb_n;
      ready_q     <= ready_n;
      rdata_q     <= rdata_n;
      ddr_rd_req  <= rd_req_n;
      ddr_wr_req  <= wr_req_n;
      ddr_addr    <= daddr_n;
      ddr_wr_data <= dwdata_n;
      rv_q        <= ddr_rd_valid;
      rd_q        <= ddr_rd_data;
    end
  end

`ifdef DDR_MEM_BRIDGE_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt    <= '0;
      terr_q <= 1'b0;
    end else begin
      cnt    <= cnt_n;
      terr_q <= terr_n;
    end
  end
`endif

endmodule

// File: tb/tb_ddr_mem_bridge.sv
// Directed bench for ddr_mem_bridge with a latency-1 behavioural ddr_model.
module tb_ddr_mem_bridge;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ddr_rd_req, ddr_wr_req;
  logic [9:0]  ddr_addr;
  logic [31:0] ddr_wr_data, ddr_rd_data;
  logic        ddr_rd_valid;
  logic        timeout_err;

  ddr_mem_bridge_if bus ();

  ddr_mem_bridge #(
    .DATA_WIDTH(32), .ADDR_W(10), .TIMEOUT_CYCLES(64)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .ddr_rd_req(ddr_rd_req),
    .ddr_wr_req(ddr_wr_req),
    .ddr_addr(ddr_addr),
    .ddr_wr_data(ddr_wr_data),
    .ddr_rd_data(ddr_rd_data),
    .ddr_rd_valid(ddr_rd_valid),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  logic        auto_en = 1'b1;
  logic        man_valid = 1'b0;
  logic        mdl_valid = 1'b0;
  logic [31:0] mdl_data = '0;
  logic [31:0] mem [0:1023];
  int          wr_cnt = 0;
  int          rd_cnt = 0;
  logic [9:0]  last_wa = '0;
  logic [31:0] last_wd = '0;

  always @(posedge clk) begin
    if (ddr_wr_req) begin
      mem[ddr_addr] <= ddr_wr_data;
      wr_cnt  <= wr_cnt + 1;
      last_wa <= ddr_addr;
      last_wd <= ddr_wr_data;
    end
    if (ddr_rd_req) rd_cnt <= rd_cnt + 1;
    mdl_valid <= ddr_rd_req && auto_en;
    mdl_data  <= mem[ddr_addr];
  end

  assign ddr_rd_valid = mdl_valid | man_valid;
  assign ddr_rd_data  = mdl_data;

  int errs = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic txn(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                     output logic [31:0] rd, output int cyc);
    @(negedge clk);
    bus.mem_valid = 1'b1;
    bus.mem_addr  = a;
    bus.mem_wdata = d;
    bus.mem_wstrb = s;
    cyc = 0;
    while (bus.mem_ready !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("ready_seen", 32'(bus.mem_ready), 32'd1);
    rd = bus.mem_rdata;
    bus.mem_valid = 1'b0;
    @(negedge clk);
    chk("ready_width", 32'(bus.mem_ready), 32'd0);
  endtask

  logic [31:0] rd;
  int          lat;
  logic        seen;

  initial begin
    bus.mem_valid = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_wstrb = '0;

    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(bus.mem_ready), 32'd0);
    chk("rst_rdata", bus.mem_rdata, 32'd0);
    chk("rst_rd_req", 32'(ddr_rd_req), 32'd0);
    chk("rst_wr_req", 32'(ddr_wr_req), 32'd0);
    chk("rst_addr", 32'(ddr_addr), 32'd0);
    chk("rst_wdata", ddr_wr_data, 32'd0);
    chk("rst_terr", 32'(timeout_err), 32'd0);
    reset = 1'b1;

    txn(32'h028, 32'hDEADBEEF, 4'hF, rd, lat);
    chk("fw_lat", 32'(lat), 32'd2);
    chk("fw_wr_cnt", 32'(wr_cnt), 32'd1);
    chk("fw_addr", 32'(last_wa), 32'd10);
    chk("fw_data", last_wd, 32'hDEADBEEF);
    chk("fw_no_rd", 32'(rd_cnt), 32'd0);
    chk("fw_rdata", rd, 32'd0);

    txn(32'h028, 32'h0, 4'h0, rd, lat);
    chk("rd_lat", 32'(lat), 32'd4);
    chk("rd_data", rd, 32'hDEADBEEF);
    chk("rd_cnt", 32'(rd_cnt), 32'd1);

    txn(32'h028, 32'h000000AA, 4'b0001, rd, lat);
    chk("rmw_lat", 32'(lat), 32'd5);
    chk("rmw_rd_cnt", 32'(rd_cnt), 32'd2);
    chk("rmw_wr_cnt", 32'(wr_cnt), 32'd2);
    chk("rmw_data", last_wd, 32'hDEADBEAA);
    chk("rmw_rdata", rd, 32'd0);
    txn(32'h028, 32'h0, 4'h0, rd, lat);
    chk("rmw_readback", rd, 32'hDEADBEAA);

    txn(32'h030, 32'hDEADBEEF, 4'hF, rd, lat);
    txn(32'h030, 32'h11223344, 4'b1010, rd, lat);
    chk("mix_data", last_wd, 32'h11AD33EF);
    chk("mix_addr", 32'(last_wa), 32'd12);
    txn(32'h030, 32'h0, 4'h0, rd, lat);
    chk("mix_readback", rd, 32'h11AD33EF);

    txn(32'h1004, 32'h12345678, 4'hF, rd, lat);
    chk("wrap_addr", 32'(last_wa), 32'd1);
    txn(32'h004, 32'h0, 4'h0, rd, lat);
    chk("wrap_readback", rd, 32'h12345678);

    // reset while parked in RD_WAIT, then a late rd_valid must be ignored
    auto_en = 1'b0;
    @(negedge clk);
    bus.mem_valid = 1'b1;
    bus.mem_addr  = 32'h028;
    bus.mem_wstrb = 4'h0;
    repeat (2) @(negedge clk);
    chk("pre_rst_addr", 32'(ddr_addr), 32'd10);
    reset = 1'b0;
    bus.mem_valid = 1'b0;
    #1;
    chk("mid_rst_addr", 32'(ddr_addr), 32'd0);
    chk("mid_rst_wdata", ddr_wr_data, 32'd0);
    chk("mid_rst_ready", 32'(bus.mem_ready), 32'd0);
    chk("mid_rst_rd_req", 32'(ddr_rd_req), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    man_valid = 1'b1;
    @(negedge clk);
    man_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.mem_ready) seen = 1'b1;
    end
    chk("late_valid_ignored", 32'(seen), 32'd0);
    auto_en = 1'b1;
    txn(32'h028, 32'h0, 4'h0, rd, lat);
    chk("post_rst_lat", 32'(lat), 32'd4);
    chk("post_rst_data", rd, 32'hDEADBEAA);

`ifdef DDR_MEM_BRIDGE_TIMEOUT_EN
    auto_en = 1'b0;
    txn(32'h028, 32'h0, 4'h0, rd, lat);
    chk("to_lat", 32'(lat), 32'd66);
    chk("to_rdata", rd, 32'hDEADDEAD);
    repeat (5) @(negedge clk);
    chk("to_sticky", 32'(timeout_err), 32'd1);
    reset = 1'b0;
    #1;
    chk("to_clear", 32'(timeout_err), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    auto_en = 1'b1;
`else
    chk("terr_tied", 32'(timeout_err), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
